// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream plumbing: pointer and entry width functions.
package axis_pkg;

    // Pointer carries one extra wrap bit above the index.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Each stored entry is {last, data}.
    function automatic int entry_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for axis_fifo: synchronous write, asynchronous read for fall-through.
module axis_fifo_ram #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo.sv
// Parametrised synchronous AXI-Stream FIFO with tlast framing and status outputs.
// Optional store-and-forward mode is enabled by defining AXIS_FIFO_PACKET_MODE_EN.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PW      = ptr_width(DEPTH);
    localparam int AW      = PW - 1;
    localparam int ENTRY_W = entry_width(DATA_WIDTH);

    logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]        ptr_diff;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 full_reg, full_next;
    logic                 empty_reg, empty_next;
    logic                 ready_en_reg;
    logic                 wr_fire, rd_fire;
    logic [ENTRY_W-1:0]   rd_entry;

    // Ready is held low through reset and rises on the first edge after release.
    assign s_tready = ready_en_reg && !full_reg;
    assign wr_fire  = s_tvalid && s_tready;
    assign rd_fire  = m_tvalid && m_tready;

    assign count_o = count_reg;
    assign full_o  = full_reg;
    assign empty_o = empty_reg;

    assign m_tdata = rd_entry[DATA_WIDTH-1:0];
    assign m_tlast = rd_entry[DATA_WIDTH];

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(wr_fire);
        rd_ptr_next = rd_ptr_reg + PW'(rd_fire);
        ptr_diff    = wr_ptr_next - rd_ptr_next;
        count_next  = CNT_WIDTH'(ptr_diff);
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &&
                      (wr_ptr_next[AW] != rd_ptr_next[AW]);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            ready_en_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            full_reg     <= full_next;
            empty_reg    <= empty_next;
            ready_en_reg <= 1'b1;
        end
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [CNT_WIDTH-1:0] pkt_cnt_reg, pkt_cnt_next;
    logic                 rel_reg, rel_next;
    logic                 pkt_inc, pkt_dec;

    assign pkt_inc = wr_fire && s_tlast;
    assign pkt_dec = rd_fire && m_tlast;

    // rel_reg keeps a packet flowing once its first word has been offered,
    // so an oversize packet released by full does not stall mid-way.
    assign m_tvalid = !empty_reg && ((pkt_cnt_reg != '0) || full_reg || rel_reg);

    always_comb begin
        pkt_cnt_next = pkt_cnt_reg;
        if (pkt_inc && !pkt_dec) begin
            pkt_cnt_next = pkt_cnt_reg + 1'b1;
        end else if (!pkt_inc && pkt_dec) begin
            pkt_cnt_next = pkt_cnt_reg - 1'b1;
        end

        rel_next = rel_reg;
        if (empty_next || pkt_dec) begin
            rel_next = 1'b0;
        end else if (m_tvalid) begin
            rel_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pkt_cnt_reg <= '0;
            rel_reg     <= 1'b0;
        end else begin
            pkt_cnt_reg <= pkt_cnt_next;
            rel_reg     <= rel_next;
        end
    end
`else
    assign m_tvalid = !empty_reg;
`endif

    axis_fifo_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i (clk_i),
        .we    (wr_fire),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata ({s_tlast, s_tdata}),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (rd_entry)
    );

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo against a queue-based reference model.
module tb_axis_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          arstn_i = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;

    int total = 0;
    int bad   = 0;

    logic [DW:0] q[$];
    int          npk = 0;
    bit          rel_m = 0;
    bit          prev_hold = 0;
    logic [DW:0] prev_obs;
    bit          last_wf, last_rf;

    always #5 clk_i = ~clk_i;

    axis_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .count_o  (count_o),
        .full_o   (full_o),
        .empty_o  (empty_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic cyc(input bit sv, input logic [DW-1:0] sd, input bit sl, input bit mr);
        bit          exp_valid;
        logic [DW:0] popped;
        s_tvalid = sv;
        s_tdata  = sd;
        s_tlast  = sl;
        m_tready = mr;
        @(negedge clk_i);
        exp_valid = (q.size() != 0);
`ifdef AXIS_FIFO_PACKET_MODE_EN
        exp_valid = exp_valid && (npk > 0 || q.size() == DEPTH || rel_m);
`endif
        chk("m_tvalid", m_tvalid, exp_valid);
        chk("count", count_o, q.size());
        chk("full", full_o, q.size() == DEPTH);
        chk("empty", empty_o, q.size() == 0);
        chk("s_tready", s_tready, q.size() != DEPTH);
        if (exp_valid && q.size() != 0) begin
            chk("m_data", {m_tlast, m_tdata}, q[0]);
        end
        if (prev_hold) begin
            chk("hold_stable", {m_tlast, m_tdata}, prev_obs);
        end
        last_wf   = sv && (q.size() != DEPTH);
        last_rf   = exp_valid && mr;
        prev_hold = exp_valid && !mr;
        prev_obs  = {m_tlast, m_tdata};
        popped    = '0;
        @(posedge clk_i);
        #1;
        if (last_rf) begin
            popped = q.pop_front();
            if (popped[DW]) npk--;
            $display("rd data=%h last=%b", popped[DW-1:0], popped[DW]);
        end
        if (last_wf) begin
            q.push_back({sl, sd});
            if (sl) npk++;
        end
        if (q.size() == 0) rel_m = 0;
        else if (last_rf && popped[DW]) rel_m = 0;
        else if (exp_valid) rel_m = 1;
    endtask

    task automatic do_reset();
        arstn_i  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        q.delete();
        npk = 0;
        rel_m = 0;
        prev_hold = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_s_tready", s_tready, 0);
        arstn_i = 1'b1;
        #1;
        chk("rel_s_tready_same_cycle", s_tready, 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int written;
        bit seen_full;

        do_reset();

        // Fill to full plus one rejected word, then drain in order.
        for (int i = 1; i <= DEPTH + 1; i++) cyc(1, DW'(i), 0, 0);
        @(negedge clk_i);
        chk("fill_full", full_o, 1);
        chk("fill_count", count_o, DEPTH);
        chk("fill_ready", s_tready, 0);
        @(posedge clk_i); #1;
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, '0, 0, 1);

        // Full with a concurrent read: no write bypass that cycle.
        for (int i = 0; i < DEPTH; i++) cyc(1, DW'(16'h0100 + i), 0, 0);
        cyc(1, 16'h01ff, 0, 1);
        cyc(1, 16'h0200, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, '0, 0, 1);

        // Concurrent streaming through many pointer wraps.
        for (int i = 0; i < 100; i++) cyc(1, DW'(16'h1000 + i), (i % 7) == 6, 1);
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1);

        // Random traffic with ~30% read duty.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 6, DW'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) < 3);
        for (int i = 0; i < DEPTH + 4; i++) cyc(0, '0, 0, 1);

`ifdef AXIS_FIFO_PACKET_MODE_EN
        do_reset();
        // Four-word packet with idle gaps: held back until tlast is written.
        cyc(1, 16'h0A01, 0, 1); cyc(0, '0, 0, 1);
        cyc(1, 16'h0A02, 0, 1); cyc(0, '0, 0, 1);
        cyc(1, 16'h0A03, 0, 1); cyc(0, '0, 0, 1);
        @(negedge clk_i);
        chk("pkt_held", m_tvalid, 0);
        @(posedge clk_i); #1;
        cyc(1, 16'h0A04, 1, 0);
        @(negedge clk_i);
        chk("pkt_released", m_tvalid, 1);
        chk("pkt_first", m_tdata, 16'h0A01);
        @(posedge clk_i); #1;
        for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1);

        // Oversize packet released by full, drained completely.
        written = 0;
        seen_full = 0;
        for (int i = 0; i < 200 && (written < 20 || q.size() != 0); i++) begin
            cyc(written < 20, DW'(16'h0B00 + written), 0, seen_full);
            if (last_wf) written++;
            if (q.size() == DEPTH) seen_full = 1;
        end
        chk("ovs_written", written, 20);
        chk("ovs_drained", q.size(), 0);

        // Mid-transfer reset clears contents and packet count.
        cyc(1, 16'h0C01, 0, 0);
        cyc(1, 16'h0C02, 1, 0);
        cyc(1, 16'h0C03, 0, 0);
        do_reset();
        cyc(1, 16'h0D01, 0, 0);
        cyc(0, '0, 0, 1);
        @(negedge clk_i);
        chk("rst_pkt_cleared", m_tvalid, 0);
        chk("rst_pkt_count", count_o, 1);
        @(posedge clk_i); #1;
`else
        // Mid-transfer reset discards contents.
        cyc(1, 16'h0C01, 1, 0);
        cyc(1, 16'h0C02, 0, 0);
        do_reset();
        cyc(0, '0, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_fifo.md
# axis_fifo

Parametrised synchronous AXI-Stream FIFO, the next generation of the team's `axis_if` stream plumbing. It adds configurable data width and depth, `tlast` framing, occupancy and status outputs, and an optional packet (store-and-forward) mode. It sits between stream producers and consumers such as the I2C master command and response paths, absorbing rate mismatch and backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: `tdata` width in bits, ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥2.
- `CNT_WIDTH`, default `$clog2(DEPTH+1)`: occupancy width; derived, never overridden.

Ports:
- `clk_i`, input, 1: single clock, all logic rising-edge.
- `arstn_i`, input, 1: reset, asynchronous and active-low.
- `s_tdata`, input, `DATA_WIDTH`: write-side data.
- `s_tvalid`, input, 1: write-side valid.
- `s_tlast`, input, 1: write-side end of packet.
- `s_tready`, output, 1: write-side ready.
- `m_tdata`, output, `DATA_WIDTH`: read-side data.
- `m_tvalid`, output, 1: read-side valid.
- `m_tlast`, output, 1: read-side end of packet.
- `m_tready`, input, 1: read-side ready.
- `count_o`, output, `CNT_WIDTH`: stored entries, 0..`DEPTH`.
- `full_o`, output, 1: `count_o == DEPTH`.
- `empty_o`, output, 1: `count_o == 0`.

## Operation
- Write happens when `s_tvalid && s_tready`. `s_tready = !full_o`. Each entry stores {`s_tlast`, `s_tdata`}.
- Read happens when `m_tvalid && m_tready`. The read side is first-word-fall-through: `m_tdata` and `m_tlast` show the oldest entry whenever `m_tvalid` is 1.
- Pointers `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)+1` bits. The MSB is the wrap flag.
  - Full: indices are equal and the MSBs differ.
  - Empty: the pointers are equal.
  - Pointer increments wrap modulo 2·`DEPTH`.
- Simultaneous write and read: both take effect and `count_o` is unchanged.
- Full with a read in the same cycle: `s_tready` is still 0 that cycle (no write bypass). Ready rises the next cycle.
- Empty with a write: no same-cycle bypass to the read side.
- AXIS rules:
  - `m_tvalid` never deasserts without a handshake.
  - `m_tdata` and `m_tlast` stay stable while `m_tvalid && !m_tready`.
  - The block does not require `s_tvalid` to be stable. It only samples on handshake.
- Reset values, asynchronous on `arstn_i` low: both pointers 0, `count_o` 0, `empty_o` 1, `full_o` 0, `m_tvalid` 0, `s_tready` 0. `s_tready` rises the first cycle after release. Memory contents are not reset.
- Reset mid-packet or mid-transfer discards all contents immediately. No partial packet survives.

## Timing
- Write-to-read latency: a word written in cycle N is visible with `m_tvalid`=1 in cycle N+1.
- Throughput is one word per cycle sustained on both sides concurrently.
- `count_o`, `full_o` and `empty_o` are registered. They reflect all handshakes up to the previous edge.
- `s_tready` is derived from registered `full_o`. There is no combinational path from `m_tready` to `s_tready`.

## Configuration
- Macro: `AXIS_FIFO_PACKET_MODE_EN`.
- Defined: store-and-forward mode.
  - A packet counter `pkt_cnt` (`CNT_WIDTH` bits) increments when a word with `s_tlast`=1 is written. It decrements when a word with `m_tlast`=1 is read. If both happen in the same cycle, it is unchanged.
  - `m_tvalid` = !empty && (`pkt_cnt` ≠ 0 || `full_o`). The `full_o` term releases a packet longer than `DEPTH` rather than deadlocking.
  - Once the first word of a packet is released, `m_tvalid` stays high until that packet's `tlast` handshake or until empty.
- Undefined: `m_tvalid = !empty_o`, and `tlast` is passed through only. No packet counter is synthesised.

## Structure
- Shared package `axis_pkg` holds:
  - a `ptr_width(depth)` function, returning `$clog2(DEPTH)+1`;
  - the entry struct typedef pattern {last, data} as a localparam width helper `ENTRY_W = DATA_WIDTH+1`.
- Sub-module `axis_fifo_ram`: simple dual-port array, `DEPTH`×`ENTRY_W`.
  - Synchronous write.
  - Asynchronous read at `rd_ptr` index, for fall-through; this maps to LUTRAM.
  - `axis_fifo` holds pointers, counters and handshake logic.

## Test plan
- **Reset:** `arstn_i` low for 3 cycles → `m_tvalid`=0, `count_o`=0, `empty_o`=1, `s_tready`=0. The cycle after release, `s_tready`=1.
- **Fill and drain:** `DEPTH`=16, `m_tready`=0, write 0x0001..0x0010 → `full_o`=1, `s_tready`=0, `count_o`=16. A 17th word is not accepted. Then `m_tready`=1 → 0x0001..0x0010 out in order, then `empty_o`=1.
- **Concurrent stream:** `s_tvalid`=`m_tready`=1 for 100 cycles with an incrementing pattern → one word per cycle out, `count_o` constant at 1, no loss, through ≥6 pointer wraps.
- **Backpressure stability:** random `m_tready` with a 30% duty → `m_tdata`/`m_tlast` never change while `m_tvalid && !m_tready`. The output sequence equals the input sequence.
- **Packet mode (macro defined):** write a 4-word packet, `tlast` on 0x0A04, with one idle cycle between words → `m_tvalid` stays 0 until the cycle after 0x0A04 is written. Then 0x0A01..0x0A04 are read with `m_tlast` on the 4th.
- **Oversize packet (macro defined):** write 20 words, no `tlast`, into `DEPTH`=16 → `m_tvalid` rises once `full_o`=1. All 20 words drain in order. A mid-transfer reset empties the FIFO and clears `pkt_cnt` to 0.
